// File: rtl/pc_unit.sv
// pc_unit: program counter with fetch handshake, absolute/relative redirects
// and an optional circular return-address stack.
// Build option: define PC_RAS_EN to implement the return-address stack.
module pc_unit #(
  parameter int unsigned PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_ready,
  input  logic                        br_valid,
  input  logic [1:0]                  br_mode,
  input  logic [PC_W-1:0]             br_target,
  output logic [PC_W-1:0]             pc,
  output logic                        pc_valid,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_ovf,
  output logic                        ras_unf,
  output logic                        mode_err
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  localparam logic [1:0] MODE_ABS  = 2'b00;
  localparam logic [1:0] MODE_REL  = 2'b01;
  localparam logic [1:0] MODE_CALL = 2'b10;
  localparam logic [1:0] MODE_RET  = 2'b11;

  typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic              ras_unf_q, ras_unf_d;
  logic              mode_err_q, mode_err_d;
  logic [PC_W-1:0]   pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]   ras_mem_q [RAS_DEPTH];
  logic [PC_W-1:0]   ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_sp_q, ras_sp_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
`endif

  // State register: leaves RESET on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RESET;
    else      state_q <= state_d;
  end

  // Next-state logic: RUN is sticky until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // Next pc, stack update and status pulses; redirect beats fetch advance.
  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = (state_d == ST_RUN);
    ras_ovf_d  = 1'b0;
    ras_unf_d  = 1'b0;
    mode_err_d = 1'b0;
`ifdef PC_RAS_EN
    ras_mem_d  = ras_mem_q;
    ras_sp_d   = ras_sp_q;
    ras_cnt_d  = ras_cnt_q;
`endif
    if (state_q == ST_RUN) begin
      if (br_valid) begin
        case (br_mode)
          MODE_ABS: pc_d = br_target;
          MODE_REL: pc_d = pc_q + br_target;
          MODE_CALL: begin
            pc_d = br_target;
`ifdef PC_RAS_EN
            // Circular push: when full, the write overwrites the oldest slot.
            ras_mem_d[ras_sp_q] = pc_inc;
            ras_sp_d            = ras_sp_q + PTR_W'(1);
            if (ras_cnt_q == CNT_W'(RAS_DEPTH)) ras_ovf_d = 1'b1;
            else                                ras_cnt_d = ras_cnt_q + CNT_W'(1);
`else
            mode_err_d = 1'b1;
`endif
          end
          MODE_RET: begin
`ifdef PC_RAS_EN
            if (ras_cnt_q == CNT_W'(0)) begin
              pc_d      = pc_inc;
              ras_unf_d = 1'b1;
            end else begin
              pc_d      = ras_mem_q[ras_sp_q - PTR_W'(1)];
              ras_sp_d  = ras_sp_q - PTR_W'(1);
              ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
`else
            pc_d       = pc_inc;
            mode_err_d = 1'b1;
`endif
          end
          default: pc_d = pc_q;
        endcase
      end else if (pc_valid_q && fetch_ready) begin
        pc_d = pc_inc;
      end
    end
  end

  // Registered outputs and stack bookkeeping with async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      ras_ovf_q  <= 1'b0;
      ras_unf_q  <= 1'b0;
      mode_err_q <= 1'b0;
`ifdef PC_RAS_EN
      ras_sp_q   <= '0;
      ras_cnt_q  <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ras_ovf_q  <= ras_ovf_d;
      ras_unf_q  <= ras_unf_d;
      mode_err_q <= mode_err_d;
`ifdef PC_RAS_EN
      ras_sp_q   <= ras_sp_d;
      ras_cnt_q  <= ras_cnt_d;
`endif
    end
  end

`ifdef PC_RAS_EN
  // Stack storage carries no reset; contents beyond ras_count are don't-care.
  always_ff @(posedge clk) begin
    ras_mem_q <= ras_mem_d;
  end

  assign ras_count = ras_cnt_q;
`else
  assign ras_count = '0;
`endif

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign ras_ovf  = ras_ovf_q;
  assign ras_unf  = ras_unf_q;
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// compared against a queue-based behavioural model of the counter.
module tb_pc_unit;

  localparam int unsigned PC_W      = 16;
  localparam logic [15:0] RV        = 16'h0010;
  localparam int unsigned RAS_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        br_valid;
  logic [1:0]  br_mode;
  logic [15:0] br_target;
  logic [15:0] pc;
  logic        pc_valid;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic        mode_err;

  pc_unit #(.PC_W(PC_W), .RESET_VEC(RV), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .br_valid(br_valid),
    .br_mode(br_mode), .br_target(br_target), .pc(pc), .pc_valid(pc_valid),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .mode_err(mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic        m_valid;
  logic        m_ovf, m_unf, m_err;
  logic [15:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        32'(pc),        32'(m_pc));
    check({tag, ".pc_valid"},  32'(pc_valid),  32'(m_valid));
    check({tag, ".ras_count"}, 32'(ras_count), 32'(m_ras.size()));
    check({tag, ".ras_ovf"},   32'(ras_ovf),   32'(m_ovf));
    check({tag, ".ras_unf"},   32'(ras_unf),   32'(m_unf));
    check({tag, ".mode_err"},  32'(mode_err),  32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    m_ras.delete();
  endtask

  // Model of one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [15:0] npc;
    npc = m_pc;
    m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    if (m_valid) begin
      if (br_valid) begin
        case (br_mode)
          2'd0: npc = br_target;
          2'd1: npc = 16'((32'(m_pc) + 32'(br_target)) % 65536);
          2'd2: begin
            npc = br_target;
`ifdef PC_RAS_EN
            if (m_ras.size() == RAS_DEPTH) begin
              void'(m_ras.pop_front());
              m_ovf = 1'b1;
            end
            m_ras.push_back(16'((32'(m_pc) + 1) % 65536));
`else
            m_err = 1'b1;
`endif
          end
          default: begin
`ifdef PC_RAS_EN
            if (m_ras.size() == 0) begin
              npc = 16'((32'(m_pc) + 1) % 65536);
              m_unf = 1'b1;
            end else begin
              npc = m_ras.pop_back();
            end
`else
            npc = 16'((32'(m_pc) + 1) % 65536);
            m_err = 1'b1;
`endif
          end
        endcase
      end else if (fetch_ready) begin
        npc = 16'((32'(m_pc) + 1) % 65536);
      end
    end
    m_pc = npc;
    m_valid = 1'b1;
  endtask

  // Apply inputs at the falling edge, clock once, check just after the edge.
  task automatic step(input string tag, input logic fr, input logic bv,
                      input logic [1:0] md, input logic [15:0] tgt);
    fetch_ready = fr; br_valid = bv; br_mode = md; br_target = tgt;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; fetch_ready = 1'b0; br_valid = 1'b0; br_mode = 2'd0; br_target = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");

    // Release reset; redirect on the RESET-state edge must be ignored.
    rst = 1'b1;
    step("release", 1'b1, 1'b1, 2'd0, 16'h0999);
    check("first_pc", 32'(pc), 32'h0010);
    step("fetch1", 1'b1, 1'b0, 2'd0, 16'h0);
    step("fetch2", 1'b1, 1'b0, 2'd0, 16'h0);
    step("fetch3", 1'b1, 1'b0, 2'd0, 16'h0);
    check("seq_pc", 32'(pc), 32'h0013);

    // Stall, then redirect concurrent with an accepted fetch.
    step("jmp20", 1'b0, 1'b1, 2'd0, 16'h0020);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 2'd0, 16'h0);
    check("stall_pc", 32'(pc), 32'h0020);
    step("abs1234", 1'b1, 1'b1, 2'd0, 16'h1234);
    check("abs_pc", 32'(pc), 32'h1234);

    // Relative redirect with wrap.
    step("jmp5", 1'b0, 1'b1, 2'd0, 16'h0005);
    step("rel", 1'b1, 1'b1, 2'd1, 16'hFFFA);
    check("rel_pc", 32'(pc), 32'hFFFF);
    step("wrap", 1'b1, 1'b0, 2'd0, 16'h0);
    check("wrap_pc", 32'(pc), 32'h0000);

    // Call chain overflowing the stack, then unwind past empty.
    step("jmp10", 1'b0, 1'b1, 2'd0, 16'h0010);
    for (int i = 2; i <= 6; i++) step("call", 1'b1, 1'b1, 2'd2, 16'(i * 16));
    for (int i = 0; i < 5; i++)  step("ret", 1'b1, 1'b1, 2'd3, 16'h0);
    step("settle", 1'b0, 1'b0, 2'd0, 16'h0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), 16'($urandom));

    // Mid-stream async reset with stack entries and a pending redirect.
    step("jmp40", 1'b0, 1'b1, 2'd0, 16'h0040);
    for (int i = 0; i < 3; i++) step("fill", 1'b0, 1'b1, 2'd2, 16'(16'h0100 + 16'(i)));
    fetch_ready = 1'b1; br_valid = 1'b1; br_mode = 2'd0; br_target = 16'hBEEF;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b1;
    step("release2", 1'b1, 1'b0, 2'd0, 16'h0);
    for (int i = 0; i < 50; i++)
      step("rand2", 1'($urandom), ($urandom_range(0, 1) == 0), 2'($urandom), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter with fetch handshake, absolute/relative redirects and an optional return-address stack (RAS). Sits at the front of the core: presents the fetch address to instruction memory, advances on accepted fetches, and takes redirects from the execute stage. Next-generation counter replacing the fixed 6-bit sequential/branch counter.

## Interface
- PC_W, 16: PC width in bits (4..32).
- RESET_VEC, 0: PC value loaded on reset (PC_W bits).
- RAS_DEPTH, 4: return-address stack entries (power of two, 2..16); unused when RAS compiled out.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_ready  in  1  fetch stage accepts current pc this cycle.
- br_valid  in  1  redirect request, single-cycle qualifier.
- br_mode  in  2  00 absolute, 01 relative, 10 call, 11 return.
- br_target  in  PC_W  absolute target (00, 10) or two's-complement offset (01); ignored for 11.
- pc  out  PC_W  current fetch address (registered).
- pc_valid  out  1  pc is presentable to fetch.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  one-cycle pulse: push onto full RAS.
- ras_unf  out  1  one-cycle pulse: return on empty RAS.
- mode_err  out  1  one-cycle pulse: call/return issued with RAS compiled out.

## Operation
- States: RESET (pc_valid=0) and RUN (pc_valid=1). RESET -> RUN on first clk edge after rst deasserts; RUN holds until rst asserts.
- Reset values: pc=RESET_VEC, pc_valid=0, ras_count=0, ras_ovf=0, ras_unf=0, mode_err=0; RAS contents don't-care.
- Next-pc priority in RUN: (1) br_valid, (2) pc_valid&fetch_ready -> pc+1, (3) hold.
- Redirects ignore fetch_ready; a redirect in the same cycle as an accepted fetch takes redirect only (no double advance).
- Absolute: npc = br_target.
- Relative: npc = pc + br_target, modulo 2^PC_W, offset relative to pc presented that cycle.
- Call: push pc+1 (mod 2^PC_W), npc = br_target. Full RAS: oldest entry dropped (circular), ras_count stays RAS_DEPTH, ras_ovf pulses.
- Return: pop top entry, npc = popped value. Empty RAS: npc = pc+1, ras_count stays 0, ras_unf pulses.
- br_valid in RESET state: ignored; pc remains RESET_VEC.
- All arithmetic wraps at PC_W bits; no overflow flag for pc.

## Timing
- Registered pc: every redirect/advance visible on pc one cycle after the requesting edge.
- pc_valid rises one cycle after rst release; first fetch may be accepted in that cycle.
- ras_ovf/ras_unf/mode_err asserted in the cycle after the causing request, cleared the following cycle unless re-triggered.
- ras_count updates with same one-cycle latency as pc.
- Async reset mid-operation: all outputs return to reset values immediately, in-flight redirect discarded, RAS emptied.
- Back-to-back redirects every cycle supported; each applies in order.

## Configuration
- PC_RAS_EN defined: RAS implemented as above.
- PC_RAS_EN undefined: no RAS storage; ras_count tied 0, ras_ovf/ras_unf tied 0. Call behaves as absolute jump to br_target with mode_err pulse; return behaves as npc = pc+1 with mode_err pulse. With macro defined, mode_err is tied 0.

## Test plan
- Reset then fetch_ready=1 for 4 cycles, RESET_VEC=0x0010 -> pc_valid rises 1 cycle after release; pc 0x0010,0x0011,0x0012,0x0013.
- fetch_ready=0 for 3 cycles at pc=0x0020 -> pc holds 0x0020; br_valid mode 00 target 0x1234 with fetch_ready=1 -> next pc 0x1234 only.
- PC_W=16, pc=0x0005, relative br_target=0xFFFA -> pc 0xFFFF; then accepted fetch -> pc 0x0000.
- PC_RAS_EN, RAS_DEPTH=4: 5 calls from pcs 0x10,0x20,0x30,0x40,0x50 -> ras_ovf pulses on 5th; 4 returns -> pc 0x51,0x41,0x31,0x21; 5th return -> pc = pc+1, ras_unf pulses, ras_count 0.
- PC_RAS_EN undefined: call target 0x0100 at pc 0x0008 -> pc 0x0100, mode_err pulse; return -> pc 0x0101, mode_err pulse.
- Assert rst mid-stream with ras_count=3 and pending redirect -> pc=RESET_VEC, pc_valid=0, ras_count=0 immediately, before next clk edge.
